// File: rtl/user_stream_arbiter_if.sv
// rtl/user_stream_arbiter_if.sv - stream source/sink bundle between user logic and the arbiter
interface user_stream_arbiter_if #(
    parameter int DATA_WIDTH = 64
);
    logic [3:0]              i_stream_en;
    logic [3:0]              i_str_data_valid;
    logic [3:0]              o_str_ack;
    logic [4*DATA_WIDTH-1:0] i_str_data;
    logic                    o_data_valid;
    logic                    i_ack;
    logic [DATA_WIDTH-1:0]   o_data;
    logic [1:0]              o_str_id;
    logic [3:0]              o_grant;
    logic                    o_busy;

    modport slave (
        input  i_stream_en, i_str_data_valid, i_str_data, i_ack,
        output o_str_ack, o_data_valid, o_data, o_str_id, o_grant, o_busy
    );

    modport master (
        output i_stream_en, i_str_data_valid, i_str_data, i_ack,
        input  o_str_ack, o_data_valid, o_data, o_str_id, o_grant, o_busy
    );
endinterface

// File: rtl/user_stream_arbiter.sv
// rtl/user_stream_arbiter.sv - round-robin burst arbiter merging four user streams into one registered channel
module user_stream_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BURST  = 16,
    parameter int CNT_W      = 5
) (
    input  logic                 i_user_clk,
    input  logic                 i_rst,
    user_stream_arbiter_if.slave bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t                  state, state_nx;
    logic [3:0]              grant, grant_nx;
    logic [1:0]              last, last_nx;
    logic [CNT_W-1:0]        cnt, cnt_nx;
    logic [1:0]              gidx;
    logic [1:0]              pick;
    logic                    found;
    logic [3:0]              req;
    logic                    ld;
    logic                    accept;
    logic                    data_valid_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [1:0]              str_id_q;

    assign req    = bus.i_str_data_valid & bus.i_stream_en;
    assign ld     = !data_valid_q || bus.i_ack;
    // Ack depends only on registered state and downstream ack, never on source valid.
    assign bus.o_str_ack    = (state == GRANT && ld) ? grant : 4'b0000;
    assign accept           = |(bus.o_str_ack & bus.i_str_data_valid);
    assign bus.o_data_valid = data_valid_q;
    assign bus.o_data       = data_q;
    assign bus.o_str_id     = str_id_q;
    assign bus.o_grant      = grant;
    assign bus.o_busy       = (state == GRANT);

    always_comb begin
        gidx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (grant[i]) gidx = 2'(i);
        end
    end

    // Search starts just after the last winner so it becomes lowest priority.
    always_comb begin
        found = 1'b0;
        pick  = last;
        for (int k = 1; k <= 4; k++) begin
            if (!found && req[last + 2'(k)]) begin
                found = 1'b1;
                pick  = last + 2'(k);
            end
        end
    end

    always_comb begin
        state_nx = state;
        grant_nx = grant;
        last_nx  = last;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nx = GRANT;
                    grant_nx = 4'b0001 << pick;
                    cnt_nx   = '0;
                end
            end
            GRANT: begin
                if (ld) begin
                    if (bus.i_str_data_valid[gidx]) begin
                        cnt_nx = cnt + 1'b1;
                        if (cnt_nx == CNT_W'(MAX_BURST)) begin
                            state_nx = IDLE;
                            grant_nx = 4'b0000;
                            last_nx  = gidx;
                        end
                    end else begin
                        state_nx = IDLE;
                        grant_nx = 4'b0000;
                        last_nx  = gidx;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_user_clk) begin
        if (!i_rst) begin
            state        <= IDLE;
            grant        <= 4'b0000;
            last         <= 2'd3;
            cnt          <= '0;
            data_valid_q <= 1'b0;
            data_q       <= '0;
            str_id_q     <= 2'd0;
        end else begin
            state <= state_nx;
            grant <= grant_nx;
            last  <= last_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                data_q       <= bus.i_str_data[gidx*DATA_WIDTH +: DATA_WIDTH];
                str_id_q     <= gidx;
                data_valid_q <= 1'b1;
            end else if (bus.i_ack) begin
                data_valid_q <= 1'b0;
            end
        end
    end
endmodule
